amx_input_conditioner: RTL



---
 rtl/amx_input_conditioner_if.sv | 33 +++
 rtl/amx_input_conditioner.sv | 79 +++++++
 2 files changed

// File: rtl/amx_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : amx_input_conditioner_if
// Function : Raw pad bits in; conditioned level word and edge strobes out.
// Revision : 1.0  initial release
// ============================================================================
interface amx_input_conditioner_if #(
    parameter int WIDTH     = 5,
    parameter int OUT_WIDTH = 8
);
    logic [WIDTH-1:0]     raw_in;
    logic [OUT_WIDTH-1:0] data_out;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;
    logic                 changed;

    modport master (
        output raw_in,
        input  data_out,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  raw_in,
        output data_out,
        output rise,
        output fall,
        output changed
    );
endinterface
`default_nettype wire

// File: rtl/amx_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : amx_input_conditioner
// Function : 2-flop sync, per-bit debounce, zero-extended level and edge strobes.
// Revision : 1.0  initial release
// ============================================================================
module amx_input_conditioner #(
    parameter int WIDTH     = 5,
    parameter int OUT_WIDTH = 8,
    parameter int DB_CYCLES = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    amx_input_conditioner_if.slave cond
);
    localparam int                 c_cnt_w    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_stable;
    logic [c_cnt_w-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic               r_changed;

    logic [WIDTH-1:0]   w_accept;
    logic [WIDTH-1:0]   w_rise_next;
    logic [WIDTH-1:0]   w_fall_next;

    // A bit is accepted once its mismatch has persisted through the final count.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == c_cnt_last);
        end
    end

    assign w_rise_next = ~r_stable & w_accept;
    assign w_fall_next =  r_stable & w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= cond.raw_in;
            r_sync2   <= r_sync1;
            r_rise    <= w_rise_next;
            r_fall    <= w_fall_next;
            r_changed <= |(w_rise_next | w_fall_next);
            // Counters are independent; any agreement restarts that bit only.
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_one;
                end
            end
        end
    end

    assign cond.data_out = OUT_WIDTH'(r_stable);
    assign cond.rise     = r_rise;
    assign cond.fall     = r_fall;
    assign cond.changed  = r_changed;
endmodule
`default_nettype wire
